mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV64 pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes EX/MEM outputs (ALU result, store data, rd, control bits, branch target/decision) and resolves the branch PC select.
- Performs the load/store on a variable-latency data-memory port with sub-word alignment, and stalls the pipeline while an access is outstanding.
- Registers its results into the MEM/WB pipeline register.

Parameters:
- ACK_TIMEOUT, 16: number of consecutive WAIT cycles with no dmem_ack before the access is aborted as a bus error.
- XLEN, 64: datapath width. Only 64 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alu_result  in  64  effective address / ALU result from EX/MEM
- store_data  in  64  forwarded rs2 value from EX/MEM
- funct3  in  3  access size/sign from EX/MEM
- rd  in  5  destination register
- mem_read, mem_write, mem_to_reg, reg_write, branch, branch_taken  in  1 each  EX/MEM control bits
- branch_target  in  64  EX/MEM adder output
- pc_src  out  1  branch & branch_taken (combinational)
- pc_target  out  64  branch_target passthrough
- mem_stall  out  1  freeze IF/ID/EX and the EX/MEM register
- dmem_req, dmem_we  out  1 each  memory request / write enable
- dmem_addr  out  64  doubleword-aligned address
- dmem_wdata  out  64  lane-replicated store data
- dmem_be  out  8  byte enables
- dmem_ack  in  1  access complete; rdata valid on the same cycle
- dmem_rdata  in  64  aligned doubleword read data
- memwb_read_data, memwb_alu_result  out  64 each  registered
- memwb_rd  out  5  registered
- memwb_mem_to_reg, memwb_reg_write, memwb_bus_err, memwb_misalign  out  1 each  registered

Behaviour:
- Reset: all memwb_* outputs are 0, state is IDLE, timeout counter is 0. dmem_req is forced to 0 during any cycle in which reset is high.
- access = mem_read | mem_write. When both are set, the write wins and no load data is returned.
- FSM has two states, IDLE and WAIT.
- dmem_req = (IDLE & access) | WAIT, combinational. dmem_we = mem_write.
- mem_stall = dmem_req & ~dmem_ack.
- IDLE with access and ack in the same cycle: completes with zero wait. MEM/WB captures at the next edge; state stays IDLE.
- IDLE with access and no ack: go to WAIT and clear the counter.
- WAIT with ack: go to IDLE and capture into MEM/WB.
- WAIT with no ack: counter increments each cycle. On reaching ACK_TIMEOUT, go to IDLE and capture with memwb_bus_err=1 and memwb_reg_write=0.
- While mem_stall is high, MEM/WB captures a bubble: reg_write=0, bus_err=0, misalign=0. Upstream holds the EX/MEM inputs stable.
- Non-memory instruction: MEM/WB captures alu_result, rd and the control bits every cycle with no stall. memwb_read_data is 0.
- Address and enables:
  - dmem_addr = {alu_result[63:3], 3'b000}; off = alu_result[2:0].
  - Byte-enable base masks: size b = 0x01, h = 0x03, w = 0x0F, d = 0xFF. dmem_be = mask << off.
- Store data lane replication:
  - sb: byte replicated 8 times.
  - sh: halfword replicated 4 times.
  - sw: word replicated twice.
  - sd: passthrough.
- Load extraction: data = dmem_rdata >> (off*8), then extend by funct3:
  - 000 lb (sign), 001 lh (sign), 010 lw (sign), 011 ld
  - 100 lbu (zero), 101 lhu (zero), 110 lwu (zero)
  - 111 is treated as ld.
- pc_src and pc_target are combinational and not gated by the stall. Branches never assert access.
- Reset mid-WAIT: the access is abandoned. The next cycle has dmem_req=0, state IDLE and MEM/WB cleared. A late ack arriving in IDLE with no access is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access (h with off[0]≠0, w with off[1:0]≠0, d with off≠0) issues no request and does not stall.
  - MEM/WB captures memwb_misalign=1 and memwb_reg_write=0.
- Undefined:
  - off is aligned down to the access size (low bits masked) before the be/shift computation.
  - memwb_misalign is tied 0.

Decomposition:
- Package mem_pkg holds:
  - funct3 size/sign constants (F3_LB..F3_LWU)
  - the state enum (IDLE, WAIT)
  - size-to-mask constants
- One sub-module, mem_load_align: combinational shift and sign/zero extension of dmem_rdata by off/funct3.

Test Plan:
- ld at 0x100, ack in the same cycle, rdata=0x8877665544332211 -> memwb_read_data=0x8877665544332211 at the next edge; mem_stall never high; dmem_be=0xFF.
- lb at 0x105, rdata byte5=0xF0 -> memwb_read_data=0xFFFFFFFFFFFFFFF0; lbu with the same stimulus -> 0x00000000000000F0.
- sw 0xDEADBEEF at 0x104, ack after 3 cycles:
  - dmem_be=0xF0, dmem_wdata=0xDEADBEEFDEADBEEF.
  - mem_stall high for exactly 3 cycles, with memwb_reg_write=0 on each stalled edge.
- ACK_TIMEOUT=4, ld with no ack -> after 4 WAIT cycles memwb_bus_err=1, memwb_reg_write=0, mem_stall low, state IDLE.
- Reset asserted in the 2nd WAIT cycle -> next cycle dmem_req=0 and all memwb_*=0; a later stray ack causes no MEM/WB change.
- lw at 0x102:
  - With MEM_MISALIGN_TRAP_EN: no dmem_req, memwb_misalign=1.
  - Without it: dmem_addr=0x100, dmem_be=0x0F.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   - funct3 load/store size and sign encodings (F3_LB..F3_LWU)
//   - access-size codes taken from funct3[1:0] and their byte-enable base masks
//   - MEM stage FSM state enum (IDLE, WAIT)
//   - helpers for byte-enable mask, offset alignment and misalignment detection
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] BE_MASK_B = 8'h01;
  localparam logic [7:0] BE_MASK_H = 8'h03;
  localparam logic [7:0] BE_MASK_W = 8'h0F;
  localparam logic [7:0] BE_MASK_D = 8'hFF;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return BE_MASK_B;
      SZ_H:    return BE_MASK_H;
      SZ_W:    return BE_MASK_W;
      default: return BE_MASK_D;
    endcase
  endfunction

  // Drop the low offset bits that would break natural alignment for the size.
  function automatic logic [2:0] align_off(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return off;
      SZ_H:    return {off[2:1], 1'b0};
      SZ_W:    return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      SZ_D:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts the addressed sub-word from an aligned doubleword
// and sign/zero-extends it according to funct3.
//   rdata  : aligned 64-bit doubleword from data memory
//   off    : byte offset within the doubleword (already size-aligned)
//   funct3 : load size/sign (111 behaves as ld)
//   data   : extended load result
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    data    = shifted;
    case (funct3)
      F3_LB:  data = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:  data = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:  data = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:  data = shifted;
      F3_LBU: data = {56'd0, shifted[7:0]};
      F3_LHU: data = {48'd0, shifted[15:0]};
      F3_LWU: data = {32'd0, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RV64 pipeline.
// Resolves the branch PC select, performs loads/stores on a variable-latency
// data-memory port (stalling upstream while an access is outstanding) and
// registers results into MEM/WB.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alu_result, store_data, funct3  EX/MEM address, store value, size/sign
//   rd, mem_read, mem_write,
//   mem_to_reg, reg_write,
//   branch, branch_taken,
//   branch_target                   EX/MEM destination and control bits
//   pc_src, pc_target               combinational branch redirect
//   mem_stall                       freezes IF/ID/EX and EX/MEM
//   dmem_req/we/addr/wdata/be       data-memory request side
//   dmem_ack, dmem_rdata            data-memory completion and read data
//   memwb_*                         MEM/WB pipeline register outputs
// Parameters: ACK_TIMEOUT (WAIT cycles before a bus error), XLEN (64 only).
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently aligning them down.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned XLEN        = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] memwb_read_data,
  output logic [XLEN-1:0] memwb_alu_result,
  output logic [4:0]      memwb_rd,
  output logic            memwb_mem_to_reg,
  output logic            memwb_reg_write,
  output logic            memwb_bus_err,
  output logic            memwb_misalign
);

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      size;
  logic [2:0]      off_raw;
  logic [2:0]      off;
  logic            access_raw;
  logic            access;
  logic            misalign;
  logic            timeout;
  logic            load_ok;
  logic [XLEN-1:0] load_data;

  assign size       = funct3[1:0];
  assign off_raw    = alu_result[2:0];
  assign access_raw = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access_raw & is_misaligned(size, off_raw);
  assign off      = off_raw;
`else
  assign misalign = 1'b0;
  assign off      = align_off(size, off_raw);
`endif

  assign access = access_raw & ~misalign;

  assign pc_src    = branch & branch_taken;
  assign pc_target = branch_target;

  assign dmem_we   = mem_write;
  assign dmem_addr = {alu_result[XLEN-1:3], 3'b000};
  assign dmem_be   = size_mask(size) << off;

  always_comb begin
    case (size)
      SZ_B:    dmem_wdata = {8{store_data[7:0]}};
      SZ_H:    dmem_wdata = {4{store_data[15:0]}};
      SZ_W:    dmem_wdata = {2{store_data[31:0]}};
      default: dmem_wdata = store_data;
    endcase
  end

  mem_load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (off),
    .funct3 (funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && state_d == WAIT)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

  // The timeout cycle drops mem_stall so the aborted instruction leaves
  // EX/MEM together with its bus-error capture; otherwise upstream would
  // still hold it and IDLE would immediately re-issue the same access.
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req = access;
        if (access && !dmem_ack)
          state_d = WAIT;
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset)
      dmem_req = 1'b0;
    mem_stall = dmem_req & ~dmem_ack & ~timeout;
  end

  // Stray acks while no request is up never reach MEM/WB.
  assign load_ok = dmem_req & dmem_ack & mem_read & ~mem_write;

  always_ff @(posedge clk) begin
    if (reset || mem_stall) begin
      memwb_read_data  <= '0;
      memwb_alu_result <= '0;
      memwb_rd         <= '0;
      memwb_mem_to_reg <= 1'b0;
      memwb_reg_write  <= 1'b0;
      memwb_bus_err    <= 1'b0;
      memwb_misalign   <= 1'b0;
    end else begin
      memwb_read_data  <= load_ok ? load_data : '0;
      memwb_alu_result <= alu_result;
      memwb_rd         <= rd;
      memwb_mem_to_reg <= mem_to_reg;
      memwb_reg_write  <= reg_write & ~timeout & ~misalign;
      memwb_bus_err    <= timeout;
      memwb_misalign   <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage. The stimulus
// process drives one cycle at a time and queues the values expected at that
// cycle's mid-point; a monitor process pops and compares on each negedge.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_pkg::*;

  localparam int unsigned ACK_TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] alu_result, store_data, branch_target, dmem_rdata;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        mem_read, mem_write, mem_to_reg, reg_write, branch, branch_taken, dmem_ack;
  logic        pc_src, mem_stall, dmem_req, dmem_we;
  logic [63:0] pc_target, dmem_addr, dmem_wdata, memwb_read_data, memwb_alu_result;
  logic [7:0]  dmem_be;
  logic [4:0]  memwb_rd;
  logic        memwb_mem_to_reg, memwb_reg_write, memwb_bus_err, memwb_misalign;

  mem_stage #(.ACK_TIMEOUT(ACK_TO), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .alu_result(alu_result), .store_data(store_data),
    .funct3(funct3), .rd(rd), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
    .branch_taken(branch_taken), .branch_target(branch_target), .pc_src(pc_src),
    .pc_target(pc_target), .mem_stall(mem_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .memwb_read_data(memwb_read_data), .memwb_alu_result(memwb_alu_result),
    .memwb_rd(memwb_rd), .memwb_mem_to_reg(memwb_mem_to_reg),
    .memwb_reg_write(memwb_reg_write), .memwb_bus_err(memwb_bus_err),
    .memwb_misalign(memwb_misalign)
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_REQ, K_STALL, K_WE, K_BE, K_ADDR, K_WDATA, K_PCSRC, K_PCTGT,
    K_RDATA, K_ALU, K_RD, K_M2R, K_RW, K_BERR, K_MIS
  } kind_t;

  typedef struct {
    int unsigned cyc;
    kind_t       kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input kind_t k);
    case (k)
      K_REQ:   return {63'd0, dmem_req};
      K_STALL: return {63'd0, mem_stall};
      K_WE:    return {63'd0, dmem_we};
      K_BE:    return {56'd0, dmem_be};
      K_ADDR:  return dmem_addr;
      K_WDATA: return dmem_wdata;
      K_PCSRC: return {63'd0, pc_src};
      K_PCTGT: return pc_target;
      K_RDATA: return memwb_read_data;
      K_ALU:   return memwb_alu_result;
      K_RD:    return {59'd0, memwb_rd};
      K_M2R:   return {63'd0, memwb_mem_to_reg};
      K_RW:    return {63'd0, memwb_reg_write};
      K_BERR:  return {63'd0, memwb_bus_err};
      K_MIS:   return {63'd0, memwb_misalign};
      default: return '0;
    endcase
  endfunction

  // Monitor: compare every expectation tagged with the current cycle.
  initial begin
    exp_t        e;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        a = actual(e.kind);
        if (e.cyc != cyc)
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
        else if (a === e.val)
          n_pass++;
        else
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, a, e.val, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input kind_t k, input logic [63:0] v, input string n);
    sb.push_back('{cyc, k, v, n});
  endtask

  task automatic ex_bus(input string n, input logic req, input logic stall);
    ex(K_REQ, {63'd0, req}, {n, ".req"});
    ex(K_STALL, {63'd0, stall}, {n, ".stall"});
  endtask

  task automatic ex_wb(input string n, input logic [63:0] rdata, input logic [63:0] alu,
                       input logic [4:0] r, input logic m2r, input logic rw,
                       input logic berr, input logic mis);
    ex(K_RDATA, rdata, {n, ".rdata"});
    ex(K_ALU, alu, {n, ".alu"});
    ex(K_RD, {59'd0, r}, {n, ".rd"});
    ex(K_M2R, {63'd0, m2r}, {n, ".m2r"});
    ex(K_RW, {63'd0, rw}, {n, ".rw"});
    ex(K_BERR, {63'd0, berr}, {n, ".berr"});
    ex(K_MIS, {63'd0, mis}, {n, ".mis"});
  endtask

  task automatic idle_in();
    mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
    branch = 0; branch_taken = 0; funct3 = 3'd0; rd = 5'd0;
    alu_result = '0; store_data = '0; branch_target = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic op(input logic rden, input logic wren, input logic [2:0] f3,
                    input logic [63:0] addr, input logic [63:0] sdata,
                    input logic [4:0] r, input logic rw);
    mem_read = rden; mem_write = wren; funct3 = f3; alu_result = addr;
    store_data = sdata; rd = r; reg_write = rw; mem_to_reg = rden;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;

    tick(); ex_bus("rst", 0, 0); ex_wb("rst", 0, 0, 0, 0, 0, 0, 0);
    tick(); op(1, 0, F3_LD, 64'h100, 0, 5, 1); ex(K_REQ, 0, "rst_req_force");
    tick(); reset = 1'b0; idle_in(); ex_bus("post_rst", 0, 0); ex_wb("post_rst", 0, 0, 0, 0, 0, 0, 0);

    // zero-wait loads
    tick(); op(1, 0, F3_LD, 64'h100, 0, 5, 1); dmem_ack = 1; dmem_rdata = 64'h8877665544332211;
    ex_bus("ld", 1, 0); ex(K_BE, 64'hFF, "ld.be"); ex(K_ADDR, 64'h100, "ld.addr"); ex(K_WE, 0, "ld.we");
    tick(); op(1, 0, F3_LB, 64'h105, 0, 6, 1); dmem_rdata = 64'h1122F03344556677;
    ex_wb("ld", 64'h8877665544332211, 64'h100, 5, 1, 1, 0, 0);
    ex_bus("lb", 1, 0); ex(K_BE, 64'h20, "lb.be"); ex(K_ADDR, 64'h100, "lb.addr");
    tick(); op(1, 0, F3_LBU, 64'h105, 0, 7, 1);
    ex_wb("lb", 64'hFFFFFFFFFFFFFFF0, 64'h105, 6, 1, 1, 0, 0);
    tick(); op(1, 0, F3_LW, 64'h104, 0, 8, 1); dmem_rdata = 64'h89ABCDEF01234567;
    ex_wb("lbu", 64'hF0, 64'h105, 7, 1, 1, 0, 0); ex(K_BE, 64'hF0, "lw.be");
    tick(); op(1, 0, F3_LWU, 64'h104, 0, 9, 1);
    ex_wb("lw", 64'hFFFFFFFF89ABCDEF, 64'h104, 8, 1, 1, 0, 0);
    tick(); op(1, 0, F3_LH, 64'h106, 0, 10, 1);
    ex_wb("lwu", 64'h89ABCDEF, 64'h104, 9, 1, 1, 0, 0); ex(K_BE, 64'hC0, "lh.be");
    tick(); op(1, 0, F3_LHU, 64'h102, 0, 11, 1);
    ex_wb("lh", 64'hFFFFFFFFFFFF89AB, 64'h106, 10, 1, 1, 0, 0); ex(K_BE, 64'h0C, "lhu.be");

    // non-memory and branch
    tick(); idle_in(); alu_result = 64'h55; rd = 5'd3; reg_write = 1;
    ex_wb("lhu", 64'h0123, 64'h102, 11, 1, 1, 0, 0); ex_bus("alu", 0, 0);
    tick(); idle_in(); branch = 1; branch_taken = 1; branch_target = 64'hABC0;
    ex_wb("alu", 0, 64'h55, 3, 0, 1, 0, 0); ex(K_PCSRC, 1, "br_taken.pc_src");
    ex(K_PCTGT, 64'hABC0, "br_taken.pc_target"); ex(K_REQ, 0, "br.req");
    tick(); branch_taken = 0; branch_target = 64'h1234;
    ex(K_PCSRC, 0, "br_nt.pc_src"); ex(K_PCTGT, 64'h1234, "br_nt.pc_target");
    ex_wb("br", 0, 0, 0, 0, 0, 0, 0);

    // zero-wait stores
    tick(); idle_in(); op(0, 1, 3'd0, 64'h103, 64'hFFFFFFFFFFFFFFA5, 0, 0); dmem_ack = 1;
    ex_bus("sb", 1, 0); ex(K_WE, 1, "sb.we"); ex(K_BE, 64'h08, "sb.be");
    ex(K_WDATA, 64'hA5A5A5A5A5A5A5A5, "sb.wdata"); ex(K_ADDR, 64'h100, "sb.addr");
    tick(); op(0, 1, 3'd1, 64'h106, 64'h111122223333BEEF, 0, 0);
    ex(K_BE, 64'hC0, "sh.be"); ex(K_WDATA, 64'hBEEFBEEFBEEFBEEF, "sh.wdata");
    ex_wb("sb", 0, 64'h103, 0, 0, 0, 0, 0);
    tick(); op(0, 1, 3'd3, 64'h208, 64'h0123456789ABCDEF, 0, 0);
    ex(K_BE, 64'hFF, "sd.be"); ex(K_WDATA, 64'h0123456789ABCDEF, "sd.wdata"); ex(K_ADDR, 64'h208, "sd.addr");
    tick(); op(1, 1, F3_LD, 64'h110, 64'hCAFE, 12, 1); dmem_rdata = 64'hFFFFFFFFFFFFFFFF;
    ex(K_WE, 1, "wwin.we"); ex_bus("wwin", 1, 0);

    // sw with ack after 3 cycles
    tick(); op(0, 1, 3'd2, 64'h104, 64'h12345678DEADBEEF, 0, 0); dmem_ack = 0;
    ex(K_RDATA, 0, "wwin.rdata");
    ex_bus("sw_c1", 1, 1); ex(K_BE, 64'hF0, "sw.be"); ex(K_WE, 1, "sw.we");
    ex(K_WDATA, 64'hDEADBEEFDEADBEEF, "sw.wdata"); ex(K_ADDR, 64'h100, "sw.addr");
    tick(); ex_bus("sw_c2", 1, 1); ex(K_RW, 0, "sw_c2.bubble_rw");
    tick(); ex_bus("sw_c3", 1, 1); ex(K_RW, 0, "sw_c3.bubble_rw");
    tick(); dmem_ack = 1; ex_bus("sw_ack", 1, 0); ex(K_RW, 0, "sw_ack.bubble_rw");
    tick(); idle_in(); ex_bus("sw_done", 0, 0); ex_wb("sw", 0, 64'h104, 0, 0, 0, 0, 0);

    // load with one wait cycle: bubble then data
    tick(); op(1, 0, F3_LD, 64'h180, 0, 13, 1);
    ex_bus("ldw_c1", 1, 1);
    tick(); dmem_ack = 1; dmem_rdata = 64'h0102030405060708;
    ex_bus("ldw_ack", 1, 0); ex(K_RW, 0, "ldw.bubble_rw");
    tick(); idle_in(); ex_wb("ldw", 64'h0102030405060708, 64'h180, 13, 1, 1, 0, 0);

    // ack timeout after ACK_TO wait cycles
    tick(); op(1, 0, F3_LD, 64'h200, 0, 7, 1);
    ex_bus("to_c1", 1, 1);
    for (int unsigned i = 0; i < ACK_TO - 1; i++) begin
      tick(); ex_bus("to_wait", 1, 1); ex(K_RW, 0, "to_wait.bubble_rw"); ex(K_BERR, 0, "to_wait.berr");
    end
    tick(); ex_bus("to_last", 1, 0); ex(K_RW, 0, "to_last.bubble_rw");
    tick(); idle_in(); ex_bus("to_done", 0, 0);
    ex(K_BERR, 1, "to.berr"); ex(K_RW, 0, "to.rw"); ex(K_MIS, 0, "to.mis"); ex(K_RDATA, 0, "to.rdata");
    tick(); ex(K_BERR, 0, "to_after.berr");

    // reset in the 2nd wait cycle, then a stray ack
    tick(); op(1, 0, F3_LD, 64'h300, 0, 9, 1);
    ex_bus("rw_c1", 1, 1);
    tick(); ex_bus("rw_w1", 1, 1);
    tick(); reset = 1'b1; ex_bus("rw_rst", 0, 0);
    tick(); reset = 1'b0; idle_in(); ex_bus("rw_after", 0, 0); ex_wb("rw_after", 0, 0, 0, 0, 0, 0, 0);
    tick(); dmem_ack = 1; dmem_rdata = 64'hDEADDEADDEADDEAD; ex(K_REQ, 0, "stray.req");
    tick(); dmem_ack = 0; ex(K_REQ, 0, "stray_after.req"); ex_wb("stray", 0, 0, 0, 0, 0, 0, 0);

    // lw at 0x102
    tick(); op(1, 0, F3_LW, 64'h102, 0, 14, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    ex_bus("lw_mis", 0, 0);
    tick(); idle_in(); ex(K_MIS, 1, "lw_mis.mis"); ex(K_RW, 0, "lw_mis.rw"); ex(K_REQ, 0, "lw_mis_after.req");
`else
    dmem_ack = 1; dmem_rdata = 64'h89ABCDEF01234567;
    ex_bus("lw_mis", 1, 0); ex(K_ADDR, 64'h100, "lw_mis.addr"); ex(K_BE, 64'h0F, "lw_mis.be");
    tick(); idle_in(); ex_wb("lw_mis", 64'h01234567, 64'h102, 14, 1, 1, 0, 0);
`endif

    tick();
    tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: expectation never sampled (cycle %0d)", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
